// File: rtl/cmd_burst_ram.sv
// ============================================================================
// Module   : cmd_burst_ram
// Brief    : Command-driven single-port RAM with auto-increment pointers and
//            a backpressured read-data output queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cmd_burst_ram #(
    parameter int MEM_WIDTH  = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int AUTO_INC   = 1,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 a_rst_n,
    input  logic [MEM_WIDTH+1:0] din,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 addr_err
);

    localparam int                    C_QAW       = $clog2(OUT_DEPTH);
    localparam logic [MEM_WIDTH:0]    C_DEPTH_EXT = (MEM_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] C_LAST      = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [C_QAW+1:0]      C_OUT_DEPTH = (C_QAW+2)'(OUT_DEPTH);
    localparam logic [1:0]            C_OP_SETW   = 2'b00;
    localparam logic [1:0]            C_OP_WRITE  = 2'b01;
    localparam logic [1:0]            C_OP_SETR   = 2'b10;
    localparam logic [1:0]            C_OP_READ   = 2'b11;

    if (MEM_WIDTH < ADDR_WIDTH) begin : g_width_check
        $error("cmd_burst_ram: MEM_WIDTH must be >= ADDR_WIDTH");
    end
    if ((OUT_DEPTH < 2) || ((1 << C_QAW) != OUT_DEPTH)) begin : g_outq_check
        $error("cmd_burst_ram: OUT_DEPTH must be a power of two >= 2");
    end

    logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
    logic [MEM_WIDTH-1:0]  q_mem [OUT_DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic                  addr_err_q, addr_err_d;
    logic                  rd_valid_q;
    logic [MEM_WIDTH-1:0]  rd_data_q;
    logic [C_QAW-1:0]      q_wr_q, q_rd_q;
    logic [C_QAW:0]        q_cnt_q;

    logic [1:0]            w_op;
    logic [MEM_WIDTH-1:0]  w_pl;
    logic                  w_accept, w_pl_bad, w_mem_we, w_rd_req, w_push, w_pop;
    logic [C_QAW+1:0]      w_occ;

    function automatic logic [ADDR_WIDTH-1:0] f_adv(input logic [ADDR_WIDTH-1:0] p);
        if (AUTO_INC == 0) return p;
        return (p == C_LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign w_op     = din[MEM_WIDTH+1:MEM_WIDTH];
    assign w_pl     = din[MEM_WIDTH-1:0];
    assign w_accept = rx_valid && rx_ready;
    assign w_pl_bad = ({1'b0, w_pl} >= C_DEPTH_EXT);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        addr_err_d = 1'b0;
        w_mem_we   = 1'b0;
        w_rd_req   = 1'b0;
        if (w_accept) begin
            case (w_op)
                C_OP_SETW: begin
                    if (w_pl_bad) addr_err_d = 1'b1;
                    else          wptr_d     = w_pl[ADDR_WIDTH-1:0];
                end
                C_OP_WRITE: begin
                    w_mem_we = 1'b1;
                    wptr_d   = f_adv(wptr_q);
                end
                C_OP_SETR: begin
                    if (w_pl_bad) addr_err_d = 1'b1;
                    else          rptr_d     = w_pl[ADDR_WIDTH-1:0];
                end
                C_OP_READ: begin
                    w_rd_req = 1'b1;
                    rptr_d   = f_adv(rptr_q);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            addr_err_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            addr_err_q <= addr_err_d;
            rd_valid_q <= w_rd_req;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointer/count state.
    always_ff @(posedge clk) begin
        if (w_mem_we) mem[wptr_q] <= w_pl;
        if (w_rd_req) rd_data_q   <= mem[rptr_q];
        if (w_push)   q_mem[q_wr_q] <= rd_data_q;
    end

    assign w_push = rd_valid_q;
    assign w_pop  = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            q_wr_q  <= '0;
            q_rd_q  <= '0;
            q_cnt_q <= '0;
        end else begin
            if (w_push) q_wr_q <= q_wr_q + C_QAW'(1);
            if (w_pop)  q_rd_q <= q_rd_q + C_QAW'(1);
            case ({w_push, w_pop})
                2'b10:   q_cnt_q <= q_cnt_q + (C_QAW+1)'(1);
                2'b01:   q_cnt_q <= q_cnt_q - (C_QAW+1)'(1);
                default: q_cnt_q <= q_cnt_q;
            endcase
        end
    end

    // A read in flight reserves its queue slot so the push can never overflow.
    assign w_occ    = {1'b0, q_cnt_q} + {{(C_QAW+1){1'b0}}, rd_valid_q};
    assign rx_ready = (w_occ < C_OUT_DEPTH);
    assign tx_valid = (q_cnt_q != '0);
    assign dout     = tx_valid ? q_mem[q_rd_q] : '0;
    assign addr_err = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cmd_burst_ram.sv
// ============================================================================
// Module   : tb_cmd_burst_ram
// Brief    : Scoreboard bench for cmd_burst_ram (depth-256 and depth-5 builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cmd_burst_ram;

    logic       clk = 1'b0;
    logic       a_rst_n;
    logic [9:0] din;
    logic       rx_valid, tx_ready, sel;

    logic       rdy_a, txv_a, err_a, rdy_b, txv_b, err_b;
    logic [7:0] dout_a, dout_b;
    logic       rx_ready, tx_valid, addr_err;
    logic [7:0] dout;

    always #5 clk = ~clk;

    cmd_burst_ram #(.MEM_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1), .OUT_DEPTH(4)) u_dut_a (
        .clk(clk), .a_rst_n(a_rst_n), .din(din), .rx_valid(rx_valid && !sel),
        .rx_ready(rdy_a), .dout(dout_a), .tx_valid(txv_a),
        .tx_ready(tx_ready && !sel), .addr_err(err_a)
    );

    cmd_burst_ram #(.MEM_WIDTH(8), .MEM_DEPTH(5), .AUTO_INC(1), .OUT_DEPTH(4)) u_dut_b (
        .clk(clk), .a_rst_n(a_rst_n), .din(din), .rx_valid(rx_valid && sel),
        .rx_ready(rdy_b), .dout(dout_b), .tx_valid(txv_b),
        .tx_ready(tx_ready && sel), .addr_err(err_b)
    );

    assign rx_ready = sel ? rdy_b  : rdy_a;
    assign tx_valid = sel ? txv_b  : txv_a;
    assign addr_err = sel ? err_b  : err_a;
    assign dout     = sel ? dout_b : dout_a;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_acc = 0;
    logic [7:0] mm [2][256];
    int         wp [2];
    int         rp [2];
    logic [7:0] expq [$];
    int         pop_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one command, hold it until accepted, then update the reference model.
    task automatic send(input logic [1:0] op, input logic [7:0] pl);
        int  s     = sel ? 1 : 0;
        int  depth = sel ? 5 : 256;
        bit  e_err = 1'b0;
        bit  done  = 1'b0;
        int  n     = 0;
        din      = {op, pl};
        rx_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
            else if (++n > 100) begin
                check_eq("accept_timeout", 0, 1);
                rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        last_acc = cyc;
        case (op)
            2'd0: if (int'(pl) < depth) wp[s] = int'(pl); else e_err = 1'b1;
            2'd1: begin
                mm[s][wp[s]] = pl;
                wp[s] = (wp[s] == depth - 1) ? 0 : wp[s] + 1;
            end
            2'd2: if (int'(pl) < depth) rp[s] = int'(pl); else e_err = 1'b1;
            default: begin
                expq.push_back(mm[s][rp[s]]);
                rp[s] = (rp[s] == depth - 1) ? 0 : rp[s] + 1;
            end
        endcase
        check_eq("addr_err", 32'(addr_err), 32'(e_err));
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain_empty", expq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (a_rst_n && tx_valid && tx_ready) begin
            if (expq.size() == 0) check_eq("sb_unexpected_word", 32'(dout), 32'hFFFF_FFFF);
            else                  check_eq("sb_dout", 32'(dout), 32'(expq.pop_front()));
            pop_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        sel = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; din = '0; a_rst_n = 1'b0;
        wp = '{0, 0}; rp = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_txv", 32'(tx_valid), 0);
        check_eq("rst_dout", 32'(dout), 0);
        check_eq("rst_err", 32'(addr_err), 0);
        a_rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_rdy_a", 32'(rdy_a), 1);
        check_eq("rst_rdy_b", 32'(rdy_b), 1);
        @(posedge clk); #1;

        // Burst write/read with first-word latency
        tx_ready = 1'b1;
        send(2'd0, 8'h10);
        send(2'd1, 8'hA1); send(2'd1, 8'hB2); send(2'd1, 8'hC3);
        send(2'd2, 8'h10);
        pop_cyc.delete();
        send(2'd3, 8'h00);
        first = last_acc;
        send(2'd3, 8'h00); send(2'd3, 8'h00);
        drain();
        check_eq("burst_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check_eq("lat_w0", pop_cyc[0], first + 1);
            check_eq("lat_w1", pop_cyc[1], first + 2);
            check_eq("lat_w2", pop_cyc[2], first + 3);
        end

        // Non-power-of-two depth: wrap and range rejection
        sel = 1'b1;
        send(2'd0, 8'h04);
        send(2'd1, 8'h11); send(2'd1, 8'h22); send(2'd1, 8'h33);
        send(2'd2, 8'h04);
        send(2'd3, 8'h00); send(2'd3, 8'h00);
        drain();
        send(2'd2, 8'h07);
        @(posedge clk); #1;
        check_eq("addr_err_one_cycle", 32'(addr_err), 0);
        send(2'd2, 8'h84);
        send(2'd3, 8'h00);
        drain();

        // Backpressure: queue fills, rx_ready drops, nothing lost
        sel = 1'b0;
        tx_ready = 1'b0;
        send(2'd0, 8'h20);
        for (int i = 0; i < 6; i++) send(2'd1, 8'(8'h60 + i));
        send(2'd2, 8'h20);
        for (int i = 0; i < 4; i++) send(2'd3, 8'h00);
        check_eq("full_rx_ready", 32'(rx_ready), 0);
        @(posedge clk); #1;
        check_eq("full_txv", 32'(tx_valid), 1);
        check_eq("full_head", 32'(dout), 32'h60);
        check_eq("full_rx_ready2", 32'(rx_ready), 0);
        tx_ready = 1'b1;
        send(2'd3, 8'h00); send(2'd3, 8'h00);
        drain();

        // Write then immediate read of the same address
        send(2'd0, 8'h03); send(2'd2, 8'h03);
        send(2'd1, 8'h5A); send(2'd3, 8'h00);
        drain();

        // Idle with garbage on din: no state change
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            din = {2'(i % 4), 8'($urandom)};
            if (i % 5 == 4) check_eq("idle_txv", 32'(tx_valid), 0);
        end
        send(2'd1, 8'h3C);
        send(2'd2, 8'h04); send(2'd3, 8'h00);
        send(2'd2, 8'h03); send(2'd3, 8'h00);
        send(2'd2, 8'h20); send(2'd3, 8'h00);
        drain();

        // Reset mid-burst: 3 queued + 1 in flight
        tx_ready = 1'b0;
        send(2'd2, 8'h20);
        for (int i = 0; i < 4; i++) send(2'd3, 8'h00);
        a_rst_n = 1'b0;
        #1;
        check_eq("midrst_txv", 32'(tx_valid), 0);
        check_eq("midrst_dout", 32'(dout), 0);
        expq.delete();
        wp = '{0, 0}; rp = '{0, 0};
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        #1;
        check_eq("postrst_rdy", 32'(rx_ready), 1);
        check_eq("postrst_txv", 32'(tx_valid), 0);
        tx_ready = 1'b1;
        send(2'd1, 8'h77); send(2'd3, 8'h00);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
